// File: rtl/dacx0504_spi_master.sv
//==============================================================================
// Module      : dacx0504_spi_master
// Description : SPI initiator for the DACx0504 quad DAC. Turns single-register
//               read/write commands into 24-bit MSB-first frames on
//               DAC_SCLK/DAC_SDI/DAC_CS and captures DAC_SDO for readback.
//               A read is two frames: the read request, then a NOP frame
//               during which the DAC shifts the register contents back.
//               Optional macro READ_CHECK_EN: compare the readback header
//               against {4'h8, addr} and flag a mismatch on rsp_err.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module dacx0504_spi_master #(
    parameter int SCLK_HALF  = 1,   // DAC_CLK cycles per SCLK half-period
    parameter int CS_GAP_CYC = 2    // min DAC_CLK cycles CS high between frames
) (
    input  logic        DAC_CLK,
    input  logic        SYS_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        DAC_SCLK,
    output logic        DAC_SDI,
    output logic        DAC_CS,
    input  logic        DAC_SDO
);

    localparam int c_CNT_MAX = (SCLK_HALF > CS_GAP_CYC) ? SCLK_HALF : CS_GAP_CYC;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LD = c_CNT_W'(SCLK_HALF - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LD  = c_CNT_W'(CS_GAP_CYC - 1);
`ifdef READ_CHECK_EN
    localparam int c_CAP_W = 24;    // header is kept for the compare
`else
    localparam int c_CAP_W = 16;    // only the data field is ever delivered
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [4:0]           r_bit;      // index of the bit currently on SDI
    logic                 r_phase;    // 0: SCLK low half, 1: SCLK high half
    logic [22:0]          r_frame;    // bits still to be sent after the one on SDI
    logic                 r_rd;
    logic                 r_second;   // second (NOP / capture) frame of a read
    logic [c_CAP_W-1:0]   r_cap;
    logic                 r_ready;
    logic                 r_busy;
    logic                 r_rsp_valid;
    logic [15:0]          r_rsp_data;
    logic                 r_sclk;
    logic                 r_sdi;
    logic                 r_cs;
    logic [23:0]          w_frame;
`ifdef READ_CHECK_EN
    logic [3:0]           r_addr;
    logic                 r_rsp_err;
`endif

    // Frame image built from the command inputs, used only on accept
    always_comb begin
        w_frame = cmd_rd ? {4'h8, cmd_addr, 16'h0000} : {4'h0, cmd_addr, cmd_wdata};
    end

    // Frame sequencer: all pins and response outputs are registered here
    always_ff @(posedge DAC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit       <= 5'd0;
            r_phase     <= 1'b0;
            r_frame     <= '0;
            r_rd        <= 1'b0;
            r_second    <= 1'b0;
            r_cap       <= '0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_sclk      <= 1'b1;
            r_sdi       <= 1'b0;
            r_cs        <= 1'b1;
`ifdef READ_CHECK_EN
            r_addr      <= 4'h0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (cmd_valid && r_ready) begin
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_rd     <= cmd_rd;
                        r_second <= 1'b0;
                        r_frame  <= w_frame[22:0];
                        r_sdi    <= w_frame[23];
                        r_cs     <= 1'b0;
                        r_cnt    <= c_HALF_LD;
                        r_bit    <= 5'd23;
                        r_state  <= S_SETUP;
`ifdef READ_CHECK_EN
                        r_addr   <= cmd_addr;
`endif
                    end
                end
                S_SETUP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        // First falling edge; SDO is sampled before SCLK drops
                        r_sclk  <= 1'b0;
                        r_phase <= 1'b0;
                        r_cnt   <= c_HALF_LD;
                        r_state <= S_SHIFT;
                        if (r_second)
                            r_cap <= {r_cap[c_CAP_W-2:0], DAC_SDO};
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (!r_phase) begin
                        // Rising edge: move SDI on to the next bit
                        r_sclk  <= 1'b1;
                        r_phase <= 1'b1;
                        r_cnt   <= c_HALF_LD;
                        if (r_bit != 5'd0) begin
                            r_sdi   <= r_frame[22];
                            r_frame <= {r_frame[21:0], 1'b0};
                        end
                    end else if (r_bit == 5'd0) begin
                        r_cnt   <= c_HALF_LD;
                        r_state <= S_HOLD;
                    end else begin
                        // Falling edge: DAC takes SDI, master takes SDO
                        r_sclk  <= 1'b0;
                        r_phase <= 1'b0;
                        r_cnt   <= c_HALF_LD;
                        r_bit   <= r_bit - 5'd1;
                        if (r_second)
                            r_cap <= {r_cap[c_CAP_W-2:0], DAC_SDO};
                    end
                end
                S_HOLD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_cs    <= 1'b1;
                        r_sdi   <= 1'b0;
                        r_cnt   <= c_GAP_LD;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_rd && !r_second) begin
                        // Launch the NOP frame that clocks the readback out
                        r_second <= 1'b1;
                        r_frame  <= '0;
                        r_sdi    <= 1'b0;
                        r_cs     <= 1'b0;
                        r_cnt    <= c_HALF_LD;
                        r_bit    <= 5'd23;
                        r_state  <= S_SETUP;
                    end else if (r_rd) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_cap[15:0];
`ifdef READ_CHECK_EN
                        r_rsp_err   <= (r_cap[23:16] != {4'h8, r_addr});
`endif
                        r_state     <= S_DONE;
                    end else begin
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign DAC_SCLK  = r_sclk;
    assign DAC_SDI   = r_sdi;
    assign DAC_CS    = r_cs;
`ifdef READ_CHECK_EN
    assign rsp_err   = r_rsp_err;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dacx0504_spi_master.sv
//==============================================================================
// Module      : tb_dacx0504_spi_master
// Description : Directed bench for dacx0504_spi_master with a behavioural
//               DACx0504 register model on the SPI pins.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_dacx0504_spi_master;

    logic        DAC_CLK;
    logic        SYS_RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rd;
    logic [3:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic        DAC_SCLK;
    logic        DAC_SDI;
    logic        DAC_CS;
    logic        DAC_SDO;

    int n_vec = 0;
    int n_err = 0;

    dacx0504_spi_master #(.SCLK_HALF(1), .CS_GAP_CYC(2)) dut (
        .DAC_CLK   (DAC_CLK),
        .SYS_RST   (SYS_RST),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rd    (cmd_rd),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .DAC_SCLK  (DAC_SCLK),
        .DAC_SDI   (DAC_SDI),
        .DAC_CS    (DAC_CS),
        .DAC_SDO   (DAC_SDO)
    );

    initial DAC_CLK = 1'b0;
    always #5 DAC_CLK = ~DAC_CLK;

    // ---------------- DACx0504 behavioural model ----------------
    logic [15:0] mreg [16];
    logic [23:0] m_sh_in;
    logic [23:0] m_sh_out;
    logic [23:0] m_rdbk;
    logic        m_pend;
    logic        m_sdo_en;
    int          m_bits;
    logic [23:0] frames [$];
    int          bits_q [$];
    int          cslow_q [$];
    int          gap_q [$];
    logic [15:0] rsp_q [$];
    logic        err_q [$];
    int          cs_low_cnt;
    int          hi_cnt;
    int          sclk_viol;
    logic        prev_cs;
    logic        prev_sclk;

    initial begin
        m_pend = 1'b0; m_sdo_en = 1'b0; m_bits = 0; m_sh_in = '0; m_sh_out = '0;
        m_rdbk = '0; cs_low_cnt = 0; hi_cnt = 0; sclk_viol = 0;
        prev_cs = 1'b1; prev_sclk = 1'b1;
    end

    assign DAC_SDO = m_sdo_en & m_sh_out[23];

    // Frame start: load any pending readback onto SDO
    always @(negedge DAC_CS) begin
        m_bits     = 0;
        m_sh_in    = '0;
        cs_low_cnt = 0;
        m_sdo_en   = m_pend;
        m_sh_out   = m_pend ? m_rdbk : 24'h0;
        m_pend     = 1'b0;
    end

    // DAC samples SDI on the falling SCLK edge
    always @(negedge DAC_SCLK) begin
        if (DAC_CS === 1'b0) begin
            m_sh_in = {m_sh_in[22:0], DAC_SDI};
            m_bits++;
        end
    end

    // DAC advances SDO on the rising SCLK edge
    always @(posedge DAC_SCLK) begin
        if (DAC_CS === 1'b0)
            m_sh_out = {m_sh_out[22:0], 1'b0};
    end

    // Frame end: log it and decode complete frames only
    always @(posedge DAC_CS) begin
        frames.push_back(m_sh_in);
        bits_q.push_back(m_bits);
        cslow_q.push_back(cs_low_cnt);
        m_sdo_en = 1'b0;
        if (m_bits == 24) begin
            if (m_sh_in[23]) begin
                m_pend = 1'b1;
                m_rdbk = (m_sh_in[19:16] <= 4'hB) ?
                         {4'h8, m_sh_in[19:16], mreg[m_sh_in[19:16]]} : 24'h0;
            end else if (m_sh_in[19:16] != 4'h0 && m_sh_in[19:16] <= 4'hB) begin
                mreg[m_sh_in[19:16]] = m_sh_in[15:0];
            end
        end
    end

    // CS low/high cycle counters
    always @(posedge DAC_CLK) begin
        if (DAC_CS === 1'b0) begin
            cs_low_cnt++;
            if (hi_cnt != 0) gap_q.push_back(hi_cnt);
            hi_cnt = 0;
        end else begin
            hi_cnt++;
        end
    end

    // Response log and SCLK-while-CS-high watch
    always @(negedge DAC_CLK) begin
        if (rsp_valid === 1'b1) begin
            rsp_q.push_back(rsp_data);
            err_q.push_back(rsp_err);
        end
        if (!SYS_RST && prev_cs && DAC_CS && (DAC_SCLK !== prev_sclk))
            sclk_viol++;
        prev_cs   = DAC_CS;
        prev_sclk = DAC_SCLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (cmd_ready !== 1'b1 && k < 400) begin
            @(negedge DAC_CLK);
            k++;
        end
    endtask

    task automatic wait_idle(input string tag);
        wait_ready();
        chk({tag, "_idle"}, cmd_ready, 1);
    endtask

    // Caller is at a negedge; returns at the negedge after the accept edge
    task automatic do_cmd(input logic rd, input logic [3:0] a, input logic [15:0] d);
        wait_ready();
        cmd_rd = rd; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        @(posedge DAC_CLK);
        @(negedge DAC_CLK);
        cmd_valid = 1'b0; cmd_rd = ~rd; cmd_addr = 4'hF; cmd_wdata = 16'hFFFF;
    endtask

    int n0;
    int r0;

    initial begin
        SYS_RST = 1'b1; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_addr = 4'h0; cmd_wdata = 16'h0;
        for (int i = 0; i < 16; i++) mreg[i] = 16'h0000;
        mreg[1] = 16'hABCD; mreg[4] = 16'h0001; mreg[9] = 16'h3344; mreg[11] = 16'h7788;

        // Reset state
        repeat (3) @(negedge DAC_CLK);
        chk("rst_cs", DAC_CS, 1);
        chk("rst_sclk", DAC_SCLK, 1);
        chk("rst_sdi", DAC_SDI, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        SYS_RST = 1'b0;
        frames.delete(); bits_q.delete(); cslow_q.delete(); m_pend = 1'b0;
        @(negedge DAC_CLK);
        chk("ready_after_rst", cmd_ready, 1);
        chk("busy_after_rst", busy, 0);

        // 1: write addr 8 data 0x1234
        n0 = frames.size(); r0 = rsp_q.size();
        do_cmd(1'b0, 4'h8, 16'h1234);
        chk("t1_busy", busy, 1);
        wait_idle("t1");
        chk("t1_nframes", frames.size() - n0, 1);
        chk("t1_frame", frames[n0], 24'h081234);
        chk("t1_falls", bits_q[n0], 24);
        chk("t1_cs_low", cslow_q[n0], 50);
        chk("t1_no_rsp", rsp_q.size() - r0, 0);

        // 2: read addr 1
        n0 = frames.size(); r0 = rsp_q.size();
        do_cmd(1'b1, 4'h1, 16'hDEAD);
        wait_idle("t2");
        chk("t2_nframes", frames.size() - n0, 2);
        chk("t2_frame1", frames[n0], 24'h810000);
        chk("t2_frame2", frames[n0+1], 24'h000000);
        chk("t2_falls2", bits_q[n0+1], 24);
        chk("t2_cs_low2", cslow_q[n0+1], 50);
        chk("t2_nrsp", rsp_q.size() - r0, 1);
        chk("t2_rsp_data", rsp_q[r0], 16'hABCD);
        chk("t2_rsp_err", err_q[r0], 0);
        chk("t2_rsp_held", rsp_data, 16'hABCD);
        chk("t2_pulse_end", rsp_valid, 0);

        // 3: back-to-back reads 0xB then 0x4 with cmd_valid held high
        gap_q.delete();
        n0 = frames.size(); r0 = rsp_q.size();
        cmd_rd = 1'b1; cmd_addr = 4'hB; cmd_valid = 1'b1;
        @(posedge DAC_CLK);
        #1 cmd_addr = 4'h4;
        @(negedge DAC_CLK);
        wait_ready();
        @(posedge DAC_CLK);
        #1 cmd_valid = 1'b0; cmd_addr = 4'hF;
        @(negedge DAC_CLK);
        wait_idle("t3");
        chk("t3_nframes", frames.size() - n0, 4);
        chk("t3_frame_b", frames[n0], 24'h8B0000);
        chk("t3_frame_4", frames[n0+2], 24'h840000);
        chk("t3_nrsp", rsp_q.size() - r0, 2);
        chk("t3_rsp0", rsp_q[r0], 16'h7788);
        chk("t3_rsp1", rsp_q[r0+1], 16'h0001);
        chk("t3_ngaps", gap_q.size(), 4);
        chk("t3_gap_rd", gap_q[1], 2);
        chk("t3_gap_cmd", gap_q[2], 4);
        chk("t3_gap_rd2", gap_q[3], 2);

        // 4: reset during SHIFT of a read (addr 0xF keeps SDI high mid-frame)
        do_cmd(1'b1, 4'hF, 16'h0000);
        repeat (9) @(negedge DAC_CLK);
        chk("t4_pre_cs", DAC_CS, 0);
        chk("t4_pre_sdi", DAC_SDI, 1);
        r0 = rsp_q.size();
        #2 SYS_RST = 1'b1;
        #1;
        chk("t4_rst_cs", DAC_CS, 1);
        chk("t4_rst_sclk", DAC_SCLK, 1);
        chk("t4_rst_sdi", DAC_SDI, 0);
        chk("t4_rst_ready", cmd_ready, 0);
        repeat (3) @(negedge DAC_CLK);
        SYS_RST = 1'b0;
        repeat (4) @(negedge DAC_CLK);
        chk("t4_no_rsp", rsp_q.size() - r0, 0);
        r0 = rsp_q.size();
        do_cmd(1'b1, 4'h9, 16'h0000);
        wait_idle("t4");
        chk("t4_nrsp", rsp_q.size() - r0, 1);
        chk("t4_rsp_data", rsp_q[r0], 16'h3344);

        // 5: read of invalid address 0xC
        n0 = frames.size(); r0 = rsp_q.size();
        do_cmd(1'b1, 4'hC, 16'h0000);
        wait_idle("t5");
        chk("t5_frame1", frames[n0], 24'h8C0000);
        chk("t5_nrsp", rsp_q.size() - r0, 1);
        chk("t5_rsp_data", rsp_q[r0], 16'h0000);
`ifdef READ_CHECK_EN
        chk("t5_rsp_err", err_q[r0], 1);
`else
        chk("t5_rsp_err", err_q[r0], 0);
`endif

        // 6: cmd_valid pulses while busy are ignored
        n0 = frames.size(); r0 = rsp_q.size();
        do_cmd(1'b0, 4'h2, 16'h5A5A);
        for (int i = 0; i < 4; i++) begin
            repeat (8) @(negedge DAC_CLK);
            chk("t6_ready_low", cmd_ready, 0);
            cmd_valid = 1'b1; cmd_rd = 1'b1; cmd_addr = 4'h3; cmd_wdata = 16'hFFFF;
            @(negedge DAC_CLK);
            cmd_valid = 1'b0;
        end
        wait_idle("t6");
        repeat (5) @(negedge DAC_CLK);
        chk("t6_nframes", frames.size() - n0, 1);
        chk("t6_frame", frames[n0], 24'h025A5A);
        chk("t6_cs_idle", DAC_CS, 1);
        chk("t6_no_rsp", rsp_q.size() - r0, 0);

        chk("sclk_quiet_cs_high", sclk_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
